// File: rtl/icache_pkg.sv
// icache_pkg: shared line geometry, refill FSM states and sizing helpers.
package icache_pkg;
    localparam int DEF_NUM_BLOCKS = 4;
    localparam int DEF_BLOCK_SIZE = 2;
    localparam int LINE_BITS = 8 * DEF_BLOCK_SIZE * DEF_NUM_BLOCKS;
    localparam int LINE_WORDS = LINE_BITS / 32;
    localparam int CNT_W = $clog2(LINE_WORDS) + 1;
    typedef enum logic [2:0] {IDLE, FILL, RESP, WAIT, PF} state_t;
    function automatic int line_words(input int nb, input int bs);
        return 8 * bs * nb / 32;
    endfunction
endpackage

// File: rtl/icache_line_asm.sv
// icache_line_asm: line assembly register, one 32-bit word written per beat index.
module icache_line_asm
    import icache_pkg::*;
#(
    parameter int WORDS = LINE_WORDS,
    parameter int IDX_W = $clog2(WORDS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [31:0]        wdata,
    output logic [WORDS*32-1:0] line
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) line <= '0;
        else if (clr) line <= '0;
        else if (we)
            for (int i = 0; i < WORDS; i++)
                if (idx == IDX_W'(i)) line[i*32 +: 32] <= wdata;
    end
endmodule

// File: rtl/icache_line_fill.sv
// icache_line_fill: refills cache lines over a 32-bit bus with a one-entry next-line prefetch buffer.
module icache_line_fill
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS  = DEF_NUM_BLOCKS,
    parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
    parameter int ADDR_STRIDE = NUM_BLOCKS * 4,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               line_req_valid,
    input  logic [31:0]                        line_req_addr,
    output logic                               line_req_ready,
    output logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0] line_req_rdata,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic [31:0]                        mem_addr,
    input  logic [31:0]                        mem_rdata
);
    localparam int LW = line_words(NUM_BLOCKS, BLOCK_SIZE);
    localparam int CW = $clog2(LW) + 1;
    localparam logic [CW-1:0] LAST = CW'(LW - 1);

    state_t state;
    logic [31:0] base, pf_addr, pf_target, dem_addr;
    logic [CW-1:0] cnt;
    logic pf_valid, from_buf, aborting, pend, redir;
    logic beat, last, dem_start, pf_start, hit_sel, redir_now;
    logic [LW*32-1:0] dem_line, pf_line;

    assign beat      = mem_valid && mem_ready;
    assign last      = cnt == LAST;
    assign redir_now = line_req_valid && !pend && !redir && line_req_addr != pf_target;
    assign hit_sel   = line_req_valid && (pend || (!redir && line_req_addr == pf_target));
    assign dem_start = (state == IDLE && line_req_valid && !(pf_valid && line_req_addr == pf_addr)) ||
                       (state == PF && beat && (redir || redir_now));
    assign dem_addr  = (state == PF && redir) ? base : line_req_addr;
    assign pf_start  = state == WAIT && !line_req_valid && PREFETCH_EN && !from_buf;

    icache_line_asm #(.WORDS(LW), .IDX_W(CW)) u_dem (
        .clk(clk), .reset(reset), .clr(dem_start), .we(state == FILL && beat),
        .idx(cnt), .wdata(mem_rdata), .line(dem_line)
    );

    icache_line_asm #(.WORDS(LW), .IDX_W(CW)) u_pf (
        .clk(clk), .reset(reset), .clr(pf_start), .we(state == PF && beat),
        .idx(cnt), .wdata(mem_rdata), .line(pf_line)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            line_req_ready <= 1'b0;
            line_req_rdata <= '0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            base           <= '0;
            pf_addr        <= '0;
            pf_target      <= '0;
            cnt            <= '0;
            pf_valid       <= 1'b0;
            from_buf       <= 1'b0;
            aborting       <= 1'b0;
            pend           <= 1'b0;
            redir          <= 1'b0;
        end else begin
            line_req_ready <= 1'b0;
            case (state)
                IDLE: if (line_req_valid) begin
                    from_buf <= 1'b1;
                    state    <= RESP;
                end
                FILL: if (beat) begin
                    if (aborting || !line_req_valid || last) begin
                        mem_valid <= 1'b0;
                        state     <= (aborting || !line_req_valid) ? IDLE : RESP;
                    end else begin
                        mem_addr <= mem_addr + 32'd4;
                        cnt      <= cnt + 1'b1;
                    end
                end else if (!line_req_valid) aborting <= 1'b1;
                RESP: begin
                    line_req_ready <= 1'b1;
                    line_req_rdata <= from_buf ? pf_line : dem_line;
                    state          <= WAIT;
                end
                WAIT: if (!line_req_valid) state <= IDLE;
                PF: if (beat) begin
                    if (!(redir || redir_now) && last) begin
                        mem_valid <= 1'b0;
                        pf_valid  <= 1'b1;
                        pf_addr   <= pf_target;
                        from_buf  <= 1'b1;
                        state     <= hit_sel ? RESP : IDLE;
                    end else if (!(redir || redir_now)) begin
                        mem_addr <= mem_addr + 32'd4;
                        cnt      <= cnt + 1'b1;
                    end
                end else begin
                    pend  <= hit_sel;
                    redir <= redir || redir_now;
                    if (redir_now) base <= line_req_addr;
                end
                default: state <= IDLE;
            endcase
            // demand fills and prefetch starts override the per-state updates above
            if (dem_start) begin
                pf_valid  <= 1'b0;
                from_buf  <= 1'b0;
                base      <= dem_addr;
                mem_valid <= 1'b1;
                mem_addr  <= dem_addr;
                cnt       <= '0;
                aborting  <= 1'b0;
                pend      <= 1'b0;
                redir     <= 1'b0;
                state     <= FILL;
            end
            if (pf_start) begin
                pf_target <= base + 32'(ADDR_STRIDE);
                mem_valid <= 1'b1;
                mem_addr  <= base + 32'(ADDR_STRIDE);
                cnt       <= '0;
                pend      <= 1'b0;
                redir     <= 1'b0;
                state     <= PF;
            end
        end
    end
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: directed and random refill traffic against a scoreboard and memory model.
module tb_icache_line_fill;
    logic        clk = 0, reset = 1;
    logic        line_req_valid = 0, line_req_ready;
    logic [31:0] line_req_addr = 0;
    logic [63:0] line_req_rdata;
    logic        mem_valid, mem_ready = 0;
    logic [31:0] mem_addr, mem_rdata = 0;

    int checks = 0, errors = 0;
    int min_stall = 0, max_stall = 0, rdy_cnt = 0, mem_cyc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] mem_over[logic [31:0]];

    icache_line_fill dut (
        .clk(clk), .reset(reset), .line_req_valid(line_req_valid), .line_req_addr(line_req_addr),
        .line_req_ready(line_req_ready), .line_req_rdata(line_req_rdata), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_over.exists(a) ? mem_over[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
        check(name, idx < addr_log.size() ? {32'h0, addr_log[idx]} : 64'hFFFF_FFFF_FFFF_FFFF, {32'h0, exp});
    endtask

    // memory model: random handshake delay drawn once per presented word
    initial begin
        int stall = 0;
        bit armed = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 0;
            if (!mem_valid || reset) armed = 0;
            else begin
                if (!armed) begin stall = $urandom_range(max_stall, min_stall); armed = 1; end
                if (stall == 0) begin mem_ready = 1; mem_rdata = mem_word(mem_addr); armed = 0; end
                else stall--;
            end
        end
    end

    // monitor: scoreboard pop on ready plus bus protocol checks
    initial begin
        logic pv = 0, pr = 0, prdy = 0;
        logic [31:0] pa = 0;
        forever begin
            @(negedge clk);
            if (reset) begin pv = 0; prdy = 0; end
            else begin
                if (mem_valid) mem_cyc++;
                if (mem_valid && mem_ready) addr_log.push_back(mem_addr);
                if (pv && !pr) begin
                    check("mem_valid_held", mem_valid, 1);
                    check("mem_addr_stable", mem_addr, pa);
                end
                if (line_req_ready) begin
                    rdy_cnt++;
                    check("ready_single_cycle", prdy, 0);
                    if (exp_q.size() == 0) check("unexpected_ready", 1, 0);
                    else check("line_data", line_req_rdata, exp_q.pop_front());
                end
                pv = mem_valid; pr = mem_ready; pa = mem_addr; prdy = line_req_ready;
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [63:0] exp, output int lat);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        line_req_valid = 1; line_req_addr = a; lat = 0;
        while (!line_req_ready && lat < 300) begin @(posedge clk); #1; lat++; end
        if (!line_req_ready) begin
            check("req_timeout", 0, 1);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        line_req_valid = 0;
    endtask

    function automatic logic [63:0] line_of(input logic [31:0] a);
        return {mem_word(a + 32'd4), mem_word(a)};
    endfunction

    initial begin
        int lat, n;
        logic [31:0] a, r;
        mem_over[32'h100] = 32'h1111_1111; mem_over[32'h104] = 32'h2222_2222;
        mem_over[32'h110] = 32'h3333_3333; mem_over[32'h114] = 32'h4444_4444;
        mem_over[32'h200] = 32'h5555_5555; mem_over[32'h204] = 32'h6666_6666;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_ready", line_req_ready, 0);
        check("rst_rdata", line_req_rdata, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);

        // cold miss, then the next-line prefetch runs unprompted
        addr_log.delete();
        do_req(32'h100, 64'h2222_2222_1111_1111, lat);
        repeat (20) @(posedge clk);
        chk_log("miss_addr0", 0, 32'h100);
        chk_log("miss_addr1", 1, 32'h104);
        chk_log("pf_addr0", 2, 32'h110);
        chk_log("pf_addr1", 3, 32'h114);
        check("pf_beats", addr_log.size(), 4);

        // prefetch buffer hit
        mem_cyc = 0;
        do_req(32'h110, 64'h4444_4444_3333_3333, lat);
        check("hit_latency", lat, 2);
        repeat (10) @(posedge clk);
        check("hit_no_bus", mem_cyc, 0);

        // redirect while a prefetch beat is stalled on the bus
        min_stall = 3; max_stall = 3;
        do_req(32'h100, 64'h2222_2222_1111_1111, lat);
        n = 0;
        while (!(mem_valid && mem_addr == 32'h110) && n < 50) begin @(posedge clk); #1; n++; end
        check("pf_started", mem_valid && mem_addr == 32'h110, 1);
        addr_log.delete();
        do_req(32'h200, 64'h6666_6666_5555_5555, lat);
        chk_log("redir_pf_beat", 0, 32'h110);
        chk_log("redir_addr0", 1, 32'h200);
        chk_log("redir_addr1", 2, 32'h204);
        repeat (40) @(posedge clk);

        // abort after the first beat of a demand fill
        min_stall = 0; max_stall = 0;
        n = rdy_cnt;
        addr_log.delete();
        @(posedge clk); #1;
        line_req_valid = 1; line_req_addr = 32'h300;
        lat = 0;
        while (addr_log.size() == 0 && lat < 50) begin @(posedge clk); #1; lat++; end
        line_req_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        chk_log("abort_addr0", 0, 32'h300);
        check("abort_beats_le2", addr_log.size() <= 2, 1);
        check("abort_no_ready", rdy_cnt, n);
        check("abort_idle", mem_valid, 0);
        addr_log.delete();
        do_req(32'h300, line_of(32'h300), lat);
        chk_log("refetch_addr0", 0, 32'h300);
        chk_log("refetch_addr1", 1, 32'h304);
        repeat (20) @(posedge clk);

        // prefetch address wraps past the top of memory
        addr_log.delete();
        do_req(32'hFFFF_FFF0, line_of(32'hFFFF_FFF0), lat);
        repeat (20) @(posedge clk);
        chk_log("wrap_pf0", 2, 32'h0);
        chk_log("wrap_pf1", 3, 32'h4);
        mem_cyc = 0;
        do_req(32'h0, line_of(32'h0), lat);
        check("wrap_hit_latency", lat, 2);
        check("wrap_hit_no_bus", mem_cyc, 0);
        repeat (5) @(posedge clk);

        // reset in the middle of a fill
        min_stall = 5; max_stall = 5;
        @(posedge clk); #1;
        line_req_valid = 1; line_req_addr = 32'h400;
        lat = 0;
        while (!mem_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("rst_fill_started", mem_valid, 1);
        @(posedge clk); #1;
        reset = 1;
        #1;
        check("rst_mid_mem_valid", mem_valid, 0);
        check("rst_mid_ready", line_req_ready, 0);
        line_req_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // mixed sequential and random traffic with random stalls
        min_stall = 0; max_stall = 5;
        a = 32'h1000;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom();
            r[3:0] = 4'h0;
            a = ($urandom_range(1, 0) == 1) ? a + 32'h10 : r;
            repeat ($urandom_range(8, 0)) @(posedge clk);
            do_req(a, line_of(a), lat);
        end
        repeat (40) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
